lcd_hd44780_writer: RTL

- Downstream output stage for the POST box display path. Takes bytes (character or command, tagged by RS) from the postcode decoder over a valid/ready handshake.
- Drives an HD44780-compatible LCD in 4-bit mode: D7..D4, RS and E.
- Runs the LCD power-on initialisation sequence autonomously after reset.
- Owns all LCD bus timing, so upstream logic only sees a byte stream.

---
 rtl/lcd_defs.sv | 53 +++++
 rtl/lcd_delay_timer.sv | 29 ++
 rtl/lcd_hd44780_writer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lcd_defs.sv
// Shared definitions for the HD44780 4-bit writer: FSM states, LCD command
// constants and the power-on initialisation step ROM.
package lcd_defs;

   typedef enum logic [2:0] {
      PWR_WAIT,   // idle after reset until the LCD has powered up
      INIT_NIB,   // wait after a single init nibble
      INIT_BYTE,  // wait after an init byte
      IDLE,       // accepting bytes from upstream
      SETUP,      // dq/rs presented, E low
      STROBE,     // E high
      HOLD,       // E low, dq/rs still held
      WAIT        // post-byte execution time for user bytes
   } lcd_state_t;

   localparam logic [7:0] FUNCSET_4BIT_2LINE = 8'h28;
   localparam logic [7:0] DISP_ON            = 8'h0C;
   localparam logic [7:0] CLEAR              = 8'h01;
   localparam logic [7:0] ENTRY_INC          = 8'h06;
   localparam logic [3:0] INIT_NIB_8BIT      = 4'h3;
   localparam logic [3:0] INIT_NIB_4BIT      = 4'h2;

   // 4 single nibbles followed by 4 full bytes
   localparam int INIT_ROM_LEN = 8;

   // A single-nibble step keeps its nibble in data[7:4]; only the high
   // nibble is sent for such steps.
   typedef struct packed {
      logic       nibble_only;
      logic [7:0] data;
   } init_step_t;

   function automatic init_step_t init_rom(input logic [3:0] idx);
      init_step_t s;
      s = '0;
      case (idx)
         4'd0, 4'd1, 4'd2: s = '{nibble_only: 1'b1, data: {INIT_NIB_8BIT, 4'h0}};
         4'd3:             s = '{nibble_only: 1'b1, data: {INIT_NIB_4BIT, 4'h0}};
         4'd4:             s = '{nibble_only: 1'b0, data: FUNCSET_4BIT_2LINE};
         4'd5:             s = '{nibble_only: 1'b0, data: DISP_ON};
         4'd6:             s = '{nibble_only: 1'b0, data: CLEAR};
         4'd7:             s = '{nibble_only: 1'b0, data: ENTRY_INC};
         default:          s = '0;
      endcase
      return s;
   endfunction

   // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
   function automatic logic is_slow_cmd(input logic [7:0] d, input logic rs);
      return (!rs) && (d[7:2] == 6'd0) && (d != 8'd0);
   endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by all timed FSM states. A state loads N-1 on
// entry and leaves when done is seen, giving exactly N cycles in the state.
module lcd_delay_timer #(
   parameter int                 TIMER_W   = 16,
   parameter logic [TIMER_W-1:0] RESET_VAL = '0
) (
   input  logic               clk,
   input  logic               srst,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   output logic               done
);

   logic [TIMER_W-1:0] count_reg;

   // Reset preloads the power-on wait; otherwise load or count down to zero.
   always_ff @(posedge clk) begin
      if (srst) begin
         count_reg <= RESET_VAL;
      end else if (load) begin
         count_reg <= load_val;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign done = (count_reg == '0);

endmodule

// File: rtl/lcd_hd44780_writer.sv
// HD44780 4-bit mode writer: runs the power-on init sequence, then turns an
// RS-tagged byte stream into nibble writes with all LCD bus timing handled here.
module lcd_hd44780_writer
   import lcd_defs::*;
#(
   parameter int TIMER_W             = 16,
   parameter int E_PULSE_CYCLES      = 2,
   parameter int CMD_WAIT_CYCLES     = 160,
   parameter int CLEAR_WAIT_CYCLES   = 6560,
   parameter int INIT_WAIT_CYCLES    = 16400,
   parameter int POWERON_WAIT_CYCLES = 60000
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_rs,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [3:0] lcd_dq,
   output logic       lcd_rs,
   output logic       lcd_e,
   output logic       init_done
);

   localparam logic [TIMER_W-1:0] EP_LOAD    = TIMER_W'(E_PULSE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] CMD_LOAD   = TIMER_W'(CMD_WAIT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] CLEAR_LOAD = TIMER_W'(CLEAR_WAIT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] INIT_LOAD  = TIMER_W'(INIT_WAIT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] PWR_LOAD   = TIMER_W'(POWERON_WAIT_CYCLES - 1);
   localparam logic [3:0]         ROM_END    = 4'(INIT_ROM_LEN);

   lcd_state_t         state_reg, state_next;
   logic [3:0]         step_reg, step_next;      // next init ROM entry
   logic [7:0]         byte_reg, byte_next;      // byte currently being written
   logic               rs_reg, rs_next;
   logic               single_reg, single_next;  // only the high nibble is sent
   logic               low_reg, low_next;        // low nibble phase of a byte
   logic [3:0]         dq_reg;
   logic               rs_out_reg;
   logic               e_reg;
   logic               init_done_reg;
   init_step_t         rom_step;
   logic               timer_load;
   logic [TIMER_W-1:0] timer_val;
   logic               timer_done;

   lcd_delay_timer #(
      .TIMER_W   (TIMER_W),
      .RESET_VAL (PWR_LOAD)
   ) u_timer (
      .clk      (refclk),
      .srst     (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

   // Next-state logic: init stepping, byte acceptance and nibble sequencing.
   always_comb begin
      state_next  = state_reg;
      step_next   = step_reg;
      byte_next   = byte_reg;
      rs_next     = rs_reg;
      single_next = single_reg;
      low_next    = low_reg;
      rom_step    = init_rom(step_reg);
      case (state_reg)
         PWR_WAIT, INIT_NIB, INIT_BYTE: begin
            if (timer_done) begin
               if (step_reg == ROM_END) begin
                  state_next = IDLE;
               end else begin
                  byte_next   = rom_step.data;
                  single_next = rom_step.nibble_only;
                  rs_next     = 1'b0;
                  low_next    = 1'b0;
                  step_next   = step_reg + 4'd1;
                  state_next  = SETUP;
               end
            end
         end
         IDLE: begin
            if (in_valid) begin
               byte_next   = in_data;
               rs_next     = in_rs;
               single_next = 1'b0;
               low_next    = 1'b0;
               state_next  = SETUP;
            end
         end
         SETUP: state_next = STROBE;
         STROBE: begin
            if (timer_done) state_next = HOLD;
         end
         HOLD: begin
            if (!single_reg && !low_reg) begin
               low_next   = 1'b1;
               state_next = SETUP;
            end else if (single_reg) begin
               state_next = INIT_NIB;
            end else if (init_done_reg) begin
               state_next = WAIT;
            end else begin
               state_next = INIT_BYTE;
            end
         end
         WAIT: begin
            if (timer_done) state_next = IDLE;
         end
         default: state_next = PWR_WAIT;
      endcase
   end

   // Timer reload value for the state being entered; reload on every state change.
   always_comb begin
      case (state_next)
         STROBE:          timer_val = EP_LOAD;
         INIT_NIB:        timer_val = INIT_LOAD;
         INIT_BYTE, WAIT: timer_val = is_slow_cmd(byte_reg, rs_reg) ? CLEAR_LOAD : CMD_LOAD;
         default:         timer_val = '0;
      endcase
   end

   assign timer_load = (state_next != state_reg);

   // State and registered LCD outputs; dq/rs only change when entering SETUP.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_reg     <= PWR_WAIT;
         step_reg      <= '0;
         byte_reg      <= '0;
         rs_reg        <= 1'b0;
         single_reg    <= 1'b0;
         low_reg       <= 1'b0;
         dq_reg        <= '0;
         rs_out_reg    <= 1'b0;
         e_reg         <= 1'b0;
         init_done_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         step_reg   <= step_next;
         byte_reg   <= byte_next;
         rs_reg     <= rs_next;
         single_reg <= single_next;
         low_reg    <= low_next;
         e_reg      <= (state_next == STROBE);
         if (state_next == SETUP) begin
            dq_reg     <= low_next ? byte_next[3:0] : byte_next[7:4];
            rs_out_reg <= rs_next;
         end
         if (state_next == IDLE) begin
            init_done_reg <= 1'b1;
         end
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign lcd_dq    = dq_reg;
   assign lcd_rs    = rs_out_reg;
   assign lcd_e     = e_reg;
   assign init_done = init_done_reg;

endmodule
